// File: rtl/ctrl_pkg.sv
// Shared definitions for mc_control_unit: instruction field codes, FSM states,
// datapath select encodings and the decoded control bundle.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LWL    = 6'h22;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_LWR    = 6'h26;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MTHI   = 6'h11;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MTLO   = 6'h13;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    localparam logic [4:0] RI_BLTZ   = 5'h00;
    localparam logic [4:0] RI_BGEZ   = 5'h01;
    localparam logic [4:0] RI_BLTZAL = 5'h10;
    localparam logic [4:0] RI_BGEZAL = 5'h11;

    typedef enum logic [1:0] {EXEC, RMW_RD, LD_WAIT, MD_WAIT} ctrl_state_t;

    localparam logic [2:0] MTR_ALU = 3'd0;
    localparam logic [2:0] MTR_MEM = 3'd1;
    localparam logic [2:0] MTR_PC4 = 3'd2;
    localparam logic [2:0] MTR_HI  = 3'd3;
    localparam logic [2:0] MTR_LO  = 3'd4;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_LWL  = 2'b01;
    localparam logic [1:0] RW_LWR  = 2'b10;
    localparam logic [1:0] RW_FULL = 2'b11;

    localparam logic [1:0] HL_WRITE = 2'b11;

    typedef struct packed {
        logic       JR;
        logic       Jump;
        logic [1:0] RegWrite;
        logic [1:0] RegDst;
        logic [2:0] MemtoReg;
        logic       MemRead;
        logic       MemWrite;
        logic [1:0] HI_write;
        logic [1:0] LO_write;
        logic       delay_early;
        logic       muldiv_start;
    } ctrl_t;

endpackage

// File: rtl/muldiv_timer.sv
// Multiply/divide latency timer: loads on start, counts down to zero.
// Busy while nonzero; done marks the final (1->0) cycle.
module muldiv_timer #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy,
    output logic o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: decode plus SB/SH RMW, load wait-states, delay-slot flag.
// Define MULDIV_INTERLOCK_EN for the timed MULT/DIV path with HI/LO interlock.
module mc_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       mem_wait,
    output logic       JR,
    output logic       Jump,
    output logic [1:0] RegWrite,
    output logic [1:0] RegDst,
    output logic [2:0] MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] HI_write,
    output logic [1:0] LO_write,
    output logic       delay_early,
    output logic       stall,
    output logic       muldiv_start,
    output logic       muldiv_busy,
    output logic       in_delay_slot
);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    logic        r_in_delay_slot;

    ctrl_t       w_dec;
    ctrl_t       w_out;
    logic        w_is_load;
    logic        w_is_rmw;
    logic        w_is_hilo;
    logic        w_is_div;
    logic        w_stall;
    logic        w_issue;
    logic        w_busy;
    logic        w_done;

    always_comb begin
        w_dec          = '0;
        w_dec.RegWrite = RW_NONE;
        w_dec.RegDst   = RD_RT;
        w_dec.MemtoReg = MTR_ALU;
        w_is_load      = 1'b0;
        w_is_rmw       = 1'b0;
        w_is_hilo      = 1'b0;
        w_is_div       = (funct == FN_DIV) || (funct == FN_DIVU);
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_JR: begin
                        w_dec.JR          = 1'b1;
                        w_dec.delay_early = 1'b1;
                    end
                    FN_JALR: begin
                        w_dec.JR          = 1'b1;
                        w_dec.delay_early = 1'b1;
                        w_dec.RegWrite    = RW_FULL;
                        w_dec.RegDst      = RD_RD;
                        w_dec.MemtoReg    = MTR_PC4;
                    end
                    FN_MFHI, FN_MFLO: begin
                        w_is_hilo      = 1'b1;
                        w_dec.RegWrite = RW_FULL;
                        w_dec.RegDst   = RD_RD;
                        w_dec.MemtoReg = (funct == FN_MFHI) ? MTR_HI : MTR_LO;
                    end
                    FN_MTHI: begin
                        w_is_hilo      = 1'b1;
                        w_dec.HI_write = HL_WRITE;
                    end
                    FN_MTLO: begin
                        w_is_hilo      = 1'b1;
                        w_dec.LO_write = HL_WRITE;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        w_is_hilo          = 1'b1;
                        w_dec.muldiv_start = 1'b1;
`ifndef MULDIV_INTERLOCK_EN
                        w_dec.HI_write     = HL_WRITE;
                        w_dec.LO_write     = HL_WRITE;
`endif
                    end
                    default: begin
                        w_dec.RegWrite = RW_FULL;
                        w_dec.RegDst   = RD_RD;
                    end
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RI_BLTZ, RI_BGEZ: w_dec.delay_early = 1'b1;
                    RI_BLTZAL, RI_BGEZAL: begin
                        w_dec.delay_early = 1'b1;
                        w_dec.RegWrite    = RW_FULL;
                        w_dec.RegDst      = RD_RA;
                        w_dec.MemtoReg    = MTR_PC4;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                w_dec.Jump        = 1'b1;
                w_dec.delay_early = 1'b1;
            end
            OP_JAL: begin
                w_dec.Jump        = 1'b1;
                w_dec.delay_early = 1'b1;
                w_dec.RegWrite    = RW_FULL;
                w_dec.RegDst      = RD_RA;
                w_dec.MemtoReg    = MTR_PC4;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_dec.delay_early = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_dec.RegWrite = RW_FULL;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWL, OP_LWR: begin
                w_is_load      = 1'b1;
                w_dec.MemRead  = 1'b1;
                w_dec.MemtoReg = MTR_MEM;
                w_dec.RegWrite = (opcode == OP_LWL) ? RW_LWL :
                                 (opcode == OP_LWR) ? RW_LWR : RW_FULL;
            end
            OP_SB, OP_SH: w_is_rmw = 1'b1;
            OP_SW: w_dec.MemWrite = 1'b1;
            default: ;
        endcase
    end

    // EXEC and MD_WAIT share one path: MD_WAIT is simply EXEC re-checking the interlock.
    // RMW_RD/LD_WAIT finish an already accepted instruction held in the IR.
    always_comb begin
        w_out   = '0;
        w_stall = 1'b0;
        w_issue = 1'b0;
        w_next  = r_state;
        if (!reset) begin
            case (r_state)
                EXEC, MD_WAIT: begin
                    w_next = EXEC;
                    if (instr_valid) begin
                        if (w_is_hilo && w_busy) begin
                            w_stall = 1'b1;
                            w_next  = MD_WAIT;
                        end else if (w_is_rmw) begin
                            w_out.MemRead = 1'b1;
                            w_stall       = 1'b1;
                            w_next        = RMW_RD;
                        end else if (w_is_load && mem_wait) begin
                            w_out.MemRead = 1'b1;
                            w_stall       = 1'b1;
                            w_next        = LD_WAIT;
                        end else begin
                            w_out   = w_dec;
                            w_issue = 1'b1;
                        end
                    end
                end
                RMW_RD: begin
                    w_out.MemWrite = 1'b1;
                    w_issue        = 1'b1;
                    w_next         = EXEC;
                end
                LD_WAIT: begin
                    if (mem_wait) begin
                        w_out.MemRead = 1'b1;
                        w_stall       = 1'b1;
                    end else begin
                        w_out   = w_dec;
                        w_issue = 1'b1;
                        w_next  = EXEC;
                    end
                end
                default: w_next = EXEC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= EXEC;
            r_in_delay_slot <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_in_delay_slot <= w_out.delay_early;
            end
        end
    end

`ifdef MULDIV_INTERLOCK_EN
    muldiv_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_muldiv_timer (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_out.muldiv_start),
        .i_is_div (w_is_div),
        .o_busy   (w_busy),
        .o_done   (w_done)
    );
`else
    logic w_unused_cfg;
    assign w_busy       = 1'b0;
    assign w_done       = 1'b0;
    assign w_unused_cfg = w_is_div ^ ((MULT_CYCLES + DIV_CYCLES + CNT_W) == 32'd0);
`endif

    assign JR            = w_out.JR;
    assign Jump          = w_out.Jump;
    assign RegWrite      = w_out.RegWrite;
    assign RegDst        = w_out.RegDst;
    assign MemtoReg      = w_out.MemtoReg;
    assign MemRead       = w_out.MemRead;
    assign MemWrite      = w_out.MemWrite;
    assign HI_write      = (w_done && !reset) ? HL_WRITE : w_out.HI_write;
    assign LO_write      = (w_done && !reset) ? HL_WRITE : w_out.LO_write;
    assign delay_early   = w_out.delay_early;
    assign stall         = w_stall;
    assign muldiv_start  = w_out.muldiv_start;
    assign muldiv_busy   = w_busy && !reset;
    assign in_delay_slot = r_in_delay_slot && !reset;

endmodule
